// File: rtl/online_r4_pkg.sv
// Shared radix-4 online arithmetic definitions: signed digit type, radix, redundancy bound, illegal code.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package online_r4_pkg;

    // Signed radix-4 digit, two's complement; legal values are -3..+3
    typedef logic signed [2:0] digit_t;

    localparam int R = 4;
    localparam int A = 3;

    // Only code outside the redundant digit set {-A..+A}
    localparam logic [2:0] DIG_ILLEGAL = 3'b100;

    // Result width needed to hold sum of N digits with |d|<=3, plus sign
    function automatic int result_width(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/otf_append_r4.sv
// Appends one signed radix-4 digit to the Q/QM pair (QM = Q - 1) without carry propagation.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module otf_append_r4
    import online_r4_pkg::*;
#(
    parameter int QW = 17
) (
    input  logic [QW-1:0] q,
    input  logic [QW-1:0] qm,
    input  digit_t        d,
    output logic [QW-1:0] qn,
    output logic [QW-1:0] qmn,
    output logic          illegal
);

    logic [2:0] du;
    logic [2:0] dm1;
    logic [2:0] dp3;
    logic       neg;
    logic       pos;

    // Select shift source and appended low bits from the digit sign
    always_comb begin
        du      = d;
        dm1     = du - 3'd1;
        dp3     = du + 3'd3;
        neg     = du[2];
        pos     = !du[2] && (du != 3'd0);
        // (4+d) mod 4 equals d mod 4, so the raw low bits serve both signs
        qn      = neg ? {qm[QW-3:0], du[1:0]} : {q[QW-3:0], du[1:0]};
        qmn     = pos ? {q[QW-3:0], dm1[1:0]} : {qm[QW-3:0], dp3[1:0]};
        illegal = (du == DIG_ILLEGAL);
    end

endmodule

// File: rtl/online_otf_conv_r4.sv
// Radix-4 on-the-fly converter: MSD-first signed-digit stream to a two's-complement result per N digits.
// Latency: q/done/err visible the cycle after the edge that samples the N-th digit.
// Backpressure: none; en=0 stalls in place, start restarts, a new start is taken while done is high.
module online_otf_conv_r4
    import online_r4_pkg::*;
#(
    parameter int N  = 8,
    parameter int QW = 2 * N + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start,
    input  logic [2:0]           zi,
    output logic signed [QW-1:0] q,
    output logic                 done,
    output logic                 err,
    output logic                 busy
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t          state;
    logic [QW-1:0]   q_acc;
    logic [QW-1:0]   qm_acc;
    logic [CW-1:0]   cnt;
    logic            err_acc;

    logic            accept;
    logic            last;
    logic [QW-1:0]   src_q;
    logic [QW-1:0]   src_qm;
    logic [QW-1:0]   qn;
    logic [QW-1:0]   qmn;
    logic            illegal;
    logic            err_next;

    // Digit acceptance and seeding: a start digit always appends onto Q=0, QM=-1
    always_comb begin
        accept   = en && ((state == ACC) || start);
        src_q    = start ? '0 : q_acc;
        src_qm   = start ? '1 : qm_acc;
        last     = !start && (cnt == CW'(N - 1));
        err_next = (start ? 1'b0 : err_acc) | illegal;
    end

    otf_append_r4 #(
        .QW (QW)
    ) u_append (
        .q       (src_q),
        .qm      (src_qm),
        .d       (digit_t'(zi)),
        .qn      (qn),
        .qmn     (qmn),
        .illegal (illegal)
    );

    assign busy = (state == ACC);

    // FSM, accumulators, digit counter and registered result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            q_acc   <= '0;
            qm_acc  <= '1;
            cnt     <= '0;
            err_acc <= 1'b0;
            q       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (last) begin
                    q       <= qn;
                    err     <= err_next;
                    done    <= 1'b1;
                    q_acc   <= '0;
                    qm_acc  <= '1;
                    cnt     <= '0;
                    err_acc <= 1'b0;
                    state   <= IDLE;
                end else begin
                    q_acc   <= qn;
                    qm_acc  <= qmn;
                    cnt     <= start ? CW'(1) : cnt + CW'(1);
                    err_acc <= err_next;
                    state   <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_online_otf_conv_r4.sv
// Directed bench for the radix-4 on-the-fly converter with N=4.
// Latency: result checked one negedge after the negedge that drove the 4th digit.
// Backpressure: exercised through en gaps and mid-operand restarts.
module tb_online_otf_conv_r4;

    localparam int N  = 4;
    localparam int QW = 2 * N + 1;

    localparam logic [2:0] D0   = 3'b000;
    localparam logic [2:0] DP1  = 3'b001;
    localparam logic [2:0] DP2  = 3'b010;
    localparam logic [2:0] DP3  = 3'b011;
    localparam logic [2:0] DN1  = 3'b111;
    localparam logic [2:0] DN3  = 3'b101;
    localparam logic [2:0] DILL = 3'b100;

    logic                 clk;
    logic                 reset;
    logic                 en;
    logic                 start;
    logic [2:0]           zi;
    logic signed [QW-1:0] q;
    logic                 done;
    logic                 err;
    logic                 busy;

    int checks;
    int failures;

    online_otf_conv_r4 #(
        .N  (N),
        .QW (QW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .start (start),
        .zi    (zi),
        .q     (q),
        .done  (done),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Present one digit from the next falling edge; outputs still show the prior state
    task automatic digit(input logic [2:0] z, input logic s);
        @(negedge clk);
        en    = 1'b1;
        start = s;
        zi    = z;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en    = 1'b0;
            start = 1'b0;
            zi    = D0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        en       = 1'b0;
        start    = 1'b0;
        zi       = D0;

        // Reset state
        idle(2);
        check("rst_q", 32'(q), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // +1,+2,-1,+3 -> 95
        digit(DP1, 1'b1);
        digit(DP2, 1'b0);
        check("op1_busy", 32'(busy), 1);
        digit(DN1, 1'b0);
        digit(DP3, 1'b0);
        check("op1_nodone_early", 32'(done), 0);
        idle(1);
        check("op1_done", 32'(done), 1);
        check("op1_q", 32'(q), 95);
        check("op1_err", 32'(err), 0);
        check("op1_idle", 32'(busy), 0);
        idle(1);
        check("op1_done_pulse", 32'(done), 0);
        check("op1_q_hold", 32'(q), 95);

        // -3 x4 -> -255, then 0,0,0,-1 back to back -> -1
        digit(DN3, 1'b1);
        digit(DN3, 1'b0);
        digit(DN3, 1'b0);
        digit(DN3, 1'b0);
        digit(D0, 1'b1);
        check("neg_done", 32'(done), 1);
        check("neg_q", 32'(q), -255);
        digit(D0, 1'b0);
        check("b2b_busy", 32'(busy), 1);
        digit(D0, 1'b0);
        digit(DN1, 1'b0);
        digit(DP3, 1'b1);
        check("m1_done", 32'(done), 1);
        check("m1_q", 32'(q), -1);
        digit(DP3, 1'b0);
        digit(DP3, 1'b0);
        digit(DP3, 1'b0);
        idle(1);
        check("max_done", 32'(done), 1);
        check("max_q", 32'(q), 255);

        // Digits without start in IDLE are dropped
        idle(1);
        digit(DP2, 1'b0);
        digit(DP2, 1'b0);
        idle(1);
        check("drop_busy", 32'(busy), 0);
        check("drop_done", 32'(done), 0);
        check("drop_q", 32'(q), 255);

        // en gaps between digits
        digit(DP1, 1'b1);
        idle(1);
        check("gap1_busy", 32'(busy), 1);
        digit(DP2, 1'b0);
        idle(3);
        check("gap2_busy", 32'(busy), 1);
        digit(DN1, 1'b0);
        idle(2);
        check("gap3_busy", 32'(busy), 1);
        check("gap3_nodone", 32'(done), 0);
        digit(DP3, 1'b0);
        idle(1);
        check("gap_done", 32'(done), 1);
        check("gap_q", 32'(q), 95);

        // Restart: +2,+1 abandoned, then -1,0,0,+1 -> -63
        digit(DP2, 1'b1);
        digit(DP1, 1'b0);
        digit(DN1, 1'b1);
        check("rs_nodone1", 32'(done), 0);
        digit(D0, 1'b0);
        check("rs_nodone2", 32'(done), 0);
        digit(D0, 1'b0);
        check("rs_nodone3", 32'(done), 0);
        digit(DP1, 1'b0);
        check("rs_nodone4", 32'(done), 0);
        idle(1);
        check("rs_done", 32'(done), 1);
        check("rs_q", 32'(q), -63);
        idle(1);
        check("rs_single_pulse", 32'(done), 0);

        // Illegal second digit: +1,-4,0,0 appends as a negative digit
        digit(DP1, 1'b1);
        digit(DILL, 1'b0);
        digit(D0, 1'b0);
        digit(D0, 1'b0);
        idle(1);
        check("ill_done", 32'(done), 1);
        check("ill_err", 32'(err), 1);
        check("ill_q", 32'(q), 0);
        digit(DP1, 1'b1);
        digit(DP2, 1'b0);
        digit(DN1, 1'b0);
        digit(DP3, 1'b0);
        check("ill_err_hold", 32'(err), 1);
        idle(1);
        check("clean_err", 32'(err), 0);
        check("clean_q", 32'(q), 95);

        // Asynchronous reset mid-operand
        digit(DP3, 1'b1);
        digit(DP2, 1'b0);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_q", 32'(q), 0);
        check("arst_err", 32'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        digit(DN1, 1'b0);
        digit(DN1, 1'b0);
        idle(1);
        check("arst_nodone", 32'(done), 0);
        check("arst_idle", 32'(busy), 0);
        digit(D0, 1'b1);
        digit(D0, 1'b0);
        digit(D0, 1'b0);
        digit(DN1, 1'b0);
        idle(1);
        check("post_done", 32'(done), 1);
        check("post_q", 32'(q), -1);
        check("post_err", 32'(err), 0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
